// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, datapath
// select encodings and the controller state enumeration.
// Purely declarative; no logic, no latency, no flow control.
package riscv_ctrl_pkg;

  // RV32I major opcodes handled by the controller
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Immediate generator formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // ALU operations
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Register-file writeback source
  localparam logic [1:0] WB_MDR = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  function automatic logic op_supported(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_LOAD,
      OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: op_supported = 1'b1;
      default:                              op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_decode.sv
// ALU operation decoder: (opcode, funct3, funct7[5]) -> ALUSel.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_opcode/i_funct3/i_funct7_5 instruction fields in, o_alu_sel out.
module riscv_alu_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_sel
);

  always_comb begin
    o_alu_sel = ALU_ADD;
    if (i_opcode == OP_LUI) begin
      o_alu_sel = ALU_PASSB;
    end else if (i_opcode == OP_R || i_opcode == OP_IMM) begin
      case (i_funct3)
        // I-type bit 30 is part of the immediate, so only R-type can SUB
        3'b000: o_alu_sel = (i_opcode == OP_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001: o_alu_sel = ALU_SLL;
        3'b010: o_alu_sel = ALU_SLT;
        3'b011: o_alu_sel = ALU_SLTU;
        3'b100: o_alu_sel = ALU_XOR;
        // SRAI keeps bit 30 as the arithmetic flag, same as SRA
        3'b101: o_alu_sel = i_funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110: o_alu_sel = ALU_OR;
        3'b111: o_alu_sel = ALU_AND;
        default: o_alu_sel = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I controller: sequences fetch/decode/exec/mem/wb over one
// shared memory port and drives all datapath selects and write enables.
// Latency: ALU 4, load 5, store 4, branch/jump 3 cycles plus memory waits;
// backpressure: stalls in FETCH/MEM until mem_ready.
// Ports: clk/rst_n (sync, active-low); inst from IR; BrEq/BrLt comparator;
// mem_req/mem_ready handshake with AddrSel/MemRW; IRWEn/MDRWEn/PCWEn/RegWEn
// enables; PCSel/ImmSel/ALUSel/ASel/BSel/BrUn/WBSel selects; illegal flag;
// instret retired count.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AddrSel,
  output logic        MemRW,
  output logic        IRWEn,
  output logic        MDRWEn,
  output logic        PCWEn,
  output logic        PCSel,
  output logic        RegWEn,
  output logic        BrUn,
  output logic        ASel,
  output logic        BSel,
  output logic [2:0]  ImmSel,
  output logic [3:0]  ALUSel,
  output logic [1:0]  WBSel,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next;
  logic        r_illegal;
  logic [31:0] r_instret;
  logic        w_set_illegal;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7_5;
  logic        w_unused_inst;

  assign w_opcode      = inst[6:0];
  assign w_funct3      = inst[14:12];
  assign w_funct7_5    = inst[30];
  // register indices and immediates are consumed by the datapath, not here
  assign w_unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

  logic w_is_r, w_is_load, w_is_store, w_is_branch;
  logic w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;

  assign w_is_r      = (w_opcode == OP_R);
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_jal    = (w_opcode == OP_JAL);
  assign w_is_jalr   = (w_opcode == OP_JALR);
  assign w_is_lui    = (w_opcode == OP_LUI);
  assign w_is_auipc  = (w_opcode == OP_AUIPC);

  logic [3:0] w_alu_sel;

  riscv_alu_decode u_alu_decode (
    .i_opcode   (w_opcode),
    .i_funct3   (w_funct3),
    .i_funct7_5 (w_funct7_5),
    .o_alu_sel  (w_alu_sel)
  );

  // Datapath operand selects; held constant across EXEC, MEM and WB so the
  // ALU result (address or value) stays valid until it is consumed.
  logic       w_asel;
  logic       w_bsel;
  logic [2:0] w_imm_sel;

  assign w_asel = w_is_auipc | w_is_branch | w_is_jal;
  assign w_bsel = ~w_is_r;

  always_comb begin
    w_imm_sel = IMM_I;
    if (w_is_store)                    w_imm_sel = IMM_S;
    else if (w_is_branch)              w_imm_sel = IMM_B;
    else if (w_is_lui || w_is_auipc)   w_imm_sel = IMM_U;
    else if (w_is_jal)                 w_imm_sel = IMM_J;
  end

  logic w_br_taken;

  always_comb begin
    case (w_funct3)
      3'b000:  w_br_taken =  BrEq;  // BEQ
      3'b001:  w_br_taken = ~BrEq;  // BNE
      3'b100:  w_br_taken =  BrLt;  // BLT
      3'b101:  w_br_taken = ~BrLt;  // BGE
      3'b110:  w_br_taken =  BrLt;  // BLTU
      3'b111:  w_br_taken = ~BrLt;  // BGEU
      default: w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    mem_req       = 1'b0;
    AddrSel       = 1'b0;
    MemRW         = 1'b0;
    IRWEn         = 1'b0;
    MDRWEn        = 1'b0;
    PCWEn         = 1'b0;
    PCSel         = 1'b0;
    RegWEn        = 1'b0;
    BrUn          = 1'b0;
    ASel          = 1'b0;
    BSel          = 1'b0;
    ImmSel        = IMM_I;
    ALUSel        = ALU_ADD;
    WBSel         = WB_ALU;

    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWEn  = 1'b1;
          w_next = DECODE;
        end
      end

      DECODE: begin
        if (!op_supported(w_opcode)) begin
          w_set_illegal = 1'b1;
          w_next        = HALT;
        end else begin
          w_next = EXEC;
        end
      end

      EXEC: begin
        ASel   = w_asel;
        BSel   = w_bsel;
        ImmSel = w_imm_sel;
        ALUSel = w_alu_sel;
        if (w_is_load || w_is_store) begin
          w_next = MEM;
        end else if (w_is_branch) begin
          BrUn   = w_funct3[1];
          PCWEn  = 1'b1;
          PCSel  = w_br_taken;
          w_next = FETCH;
        end else if (w_is_jal || w_is_jalr) begin
          RegWEn = 1'b1;
          WBSel  = WB_PC4;
          PCWEn  = 1'b1;
          PCSel  = 1'b1;
          w_next = FETCH;
        end else begin
          w_next = WB;
        end
      end

      MEM: begin
        ASel    = w_asel;
        BSel    = w_bsel;
        ImmSel  = w_imm_sel;
        ALUSel  = w_alu_sel;
        mem_req = 1'b1;
        AddrSel = 1'b1;
        MemRW   = w_is_store;
        if (mem_ready) begin
          if (w_is_store) begin
            PCWEn  = 1'b1;
            w_next = FETCH;
          end else begin
            MDRWEn = 1'b1;
            w_next = WB;
          end
        end
      end

      WB: begin
        ASel   = w_asel;
        BSel   = w_bsel;
        ImmSel = w_imm_sel;
        ALUSel = w_alu_sel;
        RegWEn = 1'b1;
        WBSel  = w_is_load ? WB_MDR : WB_ALU;
        PCWEn  = 1'b1;
        w_next = FETCH;
      end

      HALT: w_next = HALT;

      default: w_next = RESET_STATE;
    endcase

    // While reset is held nothing may be written and no access started,
    // whatever state the register currently holds.
    if (!rst_n) begin
      mem_req       = 1'b0;
      MemRW         = 1'b0;
      IRWEn         = 1'b0;
      MDRWEn        = 1'b0;
      PCWEn         = 1'b0;
      PCSel         = 1'b0;
      RegWEn        = 1'b0;
      w_set_illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RESET_STATE;
      r_illegal <= 1'b0;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (PCWEn)         r_instret <= r_instret + 32'd1;
    end
  end

  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule
